axi_lite_arbiter: RTL and testbench
===================================

Name: axi_lite_arbiter

Overview:
- Parametrised N-master to 1-slave AXI-lite arbiter.
- Lets IFU, LSU and future masters (DMA, debug) share one SRAM/memory port, replacing the per-unit private SRAM instances.
- Serialises whole transactions: one read or write in flight at a time, granted round-robin.
- Sits between the pipeline masters and the single downstream memory slave.

Parameters:
- NUM_MASTERS, 2, number of upstream masters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- up_araddr/up_arvalid/up_arready  in/in/out  N*ADDR_W / N / N  per-master AR channel; master i occupies slice i
- up_rdata/up_rresp/up_rvalid/up_rready  out/out/out/in  N*DATA_W / N*2 / N / N  per-master R channel
- up_awaddr/up_awvalid/up_awready  in/in/out  N*ADDR_W / N / N  per-master AW channel
- up_wdata/up_wstrb/up_wvalid/up_wready  in/in/in/out  N*DATA_W / N*DATA_W/8 / N / N  per-master W channel
- up_bresp/up_bvalid/up_bready  out/out/in  N*2 / N / N  per-master B channel
- dn_araddr/dn_arvalid/dn_arready  out/out/in  ADDR_W / 1 / 1  downstream AR
- dn_rdata/dn_rresp/dn_rvalid/dn_rready  in/in/in/out  DATA_W / 2 / 1 / 1  downstream R
- dn_awaddr/dn_awvalid/dn_awready  out/out/in  ADDR_W / 1 / 1  downstream AW
- dn_wdata/dn_wstrb/dn_wvalid/dn_wready  out/out/out/in  DATA_W / DATA_W/8 / 1 / 1  downstream W
- dn_bresp/dn_bvalid/dn_bready  in/in/out  2 / 1 / 1  downstream B
- busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. All state registers are cleared asynchronously by reset.
- Request: req[i] = up_arvalid[i] | up_awvalid[i].
- Arbitration in IDLE:
  - Pick the first requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - Register grant index g.
  - Go to RD_ADDR if up_arvalid[g], otherwise WR_REQ. A read wins over a write from the same master.
  - Arbitration costs 1 cycle; no downstream valid is asserted in IDLE.
- RD_ADDR:
  - dn_araddr = up_araddr[g]; dn_arvalid = up_arvalid[g]; up_arready[g] = dn_arready.
  - Move to RD_DATA on the handshake.
- RD_DATA:
  - R channel forwarded combinationally: up_rvalid[g] = dn_rvalid; dn_rready = up_rready[g]; rdata/rresp routed to slice g.
  - On the handshake: rr_ptr <= g+1 (wraps to 0 at NUM_MASTERS), then IDLE.
- WR_REQ:
  - AW and W are forwarded independently from master g.
  - Flags aw_done and w_done latch each handshake; after its handshake, that channel's dn valid is forced to 0.
  - Move to WR_RESP when both are done, whether same cycle or different cycles; then clear both flags.
- WR_RESP:
  - B channel forwarded to g.
  - On the handshake: rr_ptr <= g+1, then IDLE.
- Non-granted masters, and all masters while in IDLE, see every ready and valid output at 0 and data outputs at 0.
- Reset values: state=IDLE, g=0, rr_ptr=0, aw_done=w_done=0, busy=0. Every dn_* valid/ready and every up_* valid/ready is 0; all data outputs are 0.
- Reset mid-transaction: any in-flight transfer is abandoned. The downstream slave shares the same reset.
- Masters are required to hold valid and payload stable until the handshake, per AXI. The arbiter does not re-check a request after the grant.
- Back-to-back: two masters requesting continuously alternate grants (0,1,0,1…).
- Minimum transaction cost is 1 cycle of IDLE plus the slave latency.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and treated as constant 0.
- Undefined: round-robin as described above.

Decomposition:
- Package axi_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the FSM state enum (3-bit encoding).
- One sub-module, rr_arbiter: request vector plus pointer in, one-hot grant and index out, purely combinational. Instantiated once.
- The arbiter FSM and channel muxing stay in the top module.

Test Plan:
- Single read: master 1 reads 0x8000_0004 with slave data 0xDEAD_BEEF → dn_arvalid is asserted 1 cycle after up_arvalid[1]; up_rdata[1]=0xDEAD_BEEF with rresp 00; master 0 sees no valid or ready.
- Simultaneous reads: masters 0 and 1 issue 4 reads each, both requesting continuously → grants alternate 0,1,0,1…; with ARB_FIXED_PRIO_EN, all of master 0's reads complete first.
- Split write: AW to 0x8000_0010 is accepted 3 cycles before W (data 0x1234_5678, strb 4'b0011) → one dn AW and one dn W handshake each; bresp is routed only to the writer; memory updates the low halfword only.
- Same-master contention: master 0 asserts arvalid and awvalid together → the read completes first, the write is granted next (round-robin pointer permitting), and no overlap is seen downstream.
- Back-pressure: dn_rvalid is held while up_rready[g]=0 for 5 cycles → state stays RD_DATA, rdata is stable, no new grant.
- Reset mid-write: reset is asserted in WR_REQ with aw_done=1 → all outputs go to 0 immediately; after release, state=IDLE and rr_ptr=0, and a fresh write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response codes and the arbiter FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first requester at or after
// ptr, wrapping modulo N. A constant zero ptr gives fixed priority.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/axi_lite_arbiter.sv
// N-master to 1-slave AXI-lite arbiter, one whole transaction at a time.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module axi_lite_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   up_araddr,
    input  logic [NUM_MASTERS-1:0]          up_arvalid,
    output logic [NUM_MASTERS-1:0]          up_arready,
    output logic [NUM_MASTERS*DATA_W-1:0]   up_rdata,
    output logic [NUM_MASTERS*2-1:0]        up_rresp,
    output logic [NUM_MASTERS-1:0]          up_rvalid,
    input  logic [NUM_MASTERS-1:0]          up_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   up_awaddr,
    input  logic [NUM_MASTERS-1:0]          up_awvalid,
    output logic [NUM_MASTERS-1:0]          up_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]   up_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] up_wstrb,
    input  logic [NUM_MASTERS-1:0]          up_wvalid,
    output logic [NUM_MASTERS-1:0]          up_wready,
    output logic [NUM_MASTERS*2-1:0]        up_bresp,
    output logic [NUM_MASTERS-1:0]          up_bvalid,
    input  logic [NUM_MASTERS-1:0]          up_bready,
    output logic [ADDR_W-1:0]               dn_araddr,
    output logic                            dn_arvalid,
    input  logic                            dn_arready,
    input  logic [DATA_W-1:0]               dn_rdata,
    input  logic [1:0]                      dn_rresp,
    input  logic                            dn_rvalid,
    output logic                            dn_rready,
    output logic [ADDR_W-1:0]               dn_awaddr,
    output logic                            dn_awvalid,
    input  logic                            dn_awready,
    output logic [DATA_W-1:0]               dn_wdata,
    output logic [DATA_W/8-1:0]             dn_wstrb,
    output logic                            dn_wvalid,
    input  logic                            dn_wready,
    input  logic [1:0]                      dn_bresp,
    input  logic                            dn_bvalid,
    output logic                            dn_bready,
    output logic                            busy
);

    localparam int IDX_W =
        (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int STRB_W = DATA_W / 8;

    arb_state_t       state;
    logic [IDX_W-1:0] g;
    logic             aw_done;
    logic             w_done;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       idx;
    logic                   any;

`ifdef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] ptr_next;
    assign ptr_next = (g == IDX_W'(NUM_MASTERS - 1))
                    ? '0 : g + 1'b1;
`endif

    assign req  = up_arvalid | up_awvalid;
    assign busy = (state != IDLE);

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic aw_fin, w_fin;

    assign ar_hs  = dn_arvalid & dn_arready;
    assign r_hs   = dn_rvalid & dn_rready;
    assign aw_hs  = dn_awvalid & dn_awready;
    assign w_hs   = dn_wvalid & dn_wready;
    assign b_hs   = dn_bvalid & dn_bready;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin  = w_done | w_hs;

    // Only the granted slice is ever routed; IDLE leaves everything at 0.
    always_comb begin
        dn_araddr  = '0;
        dn_arvalid = 1'b0;
        dn_rready  = 1'b0;
        dn_awaddr  = '0;
        dn_awvalid = 1'b0;
        dn_wdata   = '0;
        dn_wstrb   = '0;
        dn_wvalid  = 1'b0;
        dn_bready  = 1'b0;
        up_arready = '0;
        up_rdata   = '0;
        up_rresp   = '0;
        up_rvalid  = '0;
        up_awready = '0;
        up_wready  = '0;
        up_bresp   = '0;
        up_bvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g == IDX_W'(i)) begin
                case (state)
                    RD_ADDR: begin
                        dn_araddr     = up_araddr[i*ADDR_W +: ADDR_W];
                        dn_arvalid    = up_arvalid[i];
                        up_arready[i] = dn_arready;
                    end
                    RD_DATA: begin
                        up_rvalid[i]                 = dn_rvalid;
                        dn_rready                    = up_rready[i];
                        up_rdata[i*DATA_W +: DATA_W] = dn_rdata;
                        up_rresp[i*2 +: 2]           = dn_rresp;
                    end
                    WR_REQ: begin
                        dn_awaddr     = up_awaddr[i*ADDR_W +: ADDR_W];
                        dn_awvalid    = up_awvalid[i] & ~aw_done;
                        up_awready[i] = dn_awready & ~aw_done;
                        dn_wdata      = up_wdata[i*DATA_W +: DATA_W];
                        dn_wstrb      = up_wstrb[i*STRB_W +: STRB_W];
                        dn_wvalid     = up_wvalid[i] & ~w_done;
                        up_wready[i]  = dn_wready & ~w_done;
                    end
                    WR_RESP: begin
                        up_bvalid[i]       = dn_bvalid;
                        dn_bready          = up_bready[i];
                        up_bresp[i*2 +: 2] = dn_bresp;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            g       <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        g     <= idx;
                        state <= (|(grant & up_arvalid))
                               ? RD_ADDR : WR_REQ;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (r_hs) begin
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr <= ptr_next;
`endif
                        state  <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (aw_fin && w_fin) begin
                        state   <= WR_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_fin;
                        w_done  <= w_fin;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
`ifndef ARB_FIXED_PRIO_EN
                        rr_ptr <= ptr_next;
`endif
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: two masters, a small memory slave
// that answers SLVERR for addresses with bit 31 clear.
module tb_axi_lite_arbiter;
    import axi_lite_pkg::*;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk, reset;

    logic [NM*AW-1:0] up_araddr, up_awaddr;
    logic [NM*DW-1:0] up_rdata, up_wdata;
    logic [NM*2-1:0]  up_rresp, up_bresp;
    logic [NM*SW-1:0] up_wstrb;
    logic [NM-1:0]    up_arvalid, up_arready, up_rvalid, up_rready;
    logic [NM-1:0]    up_awvalid, up_awready, up_wvalid, up_wready;
    logic [NM-1:0]    up_bvalid, up_bready;

    logic [AW-1:0] dn_araddr, dn_awaddr;
    logic [DW-1:0] dn_rdata, dn_wdata;
    logic [SW-1:0] dn_wstrb;
    logic [1:0]    dn_rresp, dn_bresp;
    logic dn_arvalid, dn_arready, dn_rvalid, dn_rready;
    logic dn_awvalid, dn_awready, dn_wvalid, dn_wready;
    logic dn_bvalid, dn_bready, busy;

    axi_lite_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .up_araddr  (up_araddr),
        .up_arvalid (up_arvalid),
        .up_arready (up_arready),
        .up_rdata   (up_rdata),
        .up_rresp   (up_rresp),
        .up_rvalid  (up_rvalid),
        .up_rready  (up_rready),
        .up_awaddr  (up_awaddr),
        .up_awvalid (up_awvalid),
        .up_awready (up_awready),
        .up_wdata   (up_wdata),
        .up_wstrb   (up_wstrb),
        .up_wvalid  (up_wvalid),
        .up_wready  (up_wready),
        .up_bresp   (up_bresp),
        .up_bvalid  (up_bvalid),
        .up_bready  (up_bready),
        .dn_araddr  (dn_araddr),
        .dn_arvalid (dn_arvalid),
        .dn_arready (dn_arready),
        .dn_rdata   (dn_rdata),
        .dn_rresp   (dn_rresp),
        .dn_rvalid  (dn_rvalid),
        .dn_rready  (dn_rready),
        .dn_awaddr  (dn_awaddr),
        .dn_awvalid (dn_awvalid),
        .dn_awready (dn_awready),
        .dn_wdata   (dn_wdata),
        .dn_wstrb   (dn_wstrb),
        .dn_wvalid  (dn_wvalid),
        .dn_wready  (dn_wready),
        .dn_bresp   (dn_bresp),
        .dn_bvalid  (dn_bvalid),
        .dn_bready  (dn_bready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: always-ready address/data, one-cycle response.
    logic [31:0] mem [16];
    logic        got_aw, got_w;
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    int aw_cnt = 0, w_cnt = 0, last_aw_cyc = 0, last_w_cyc = 0;

    assign dn_arready = 1'b1;
    assign dn_awready = 1'b1;
    assign dn_wready  = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dn_rvalid <= 1'b0;
            dn_rdata  <= '0;
            dn_rresp  <= '0;
            dn_bvalid <= 1'b0;
            dn_bresp  <= '0;
            got_aw    <= 1'b0;
            got_w     <= 1'b0;
        end else begin
            if (dn_arvalid && dn_arready) begin
                dn_rvalid <= 1'b1;
                dn_rdata  <= mem[dn_araddr[5:2]];
                dn_rresp  <= dn_araddr[31] ? RESP_OKAY : RESP_SLVERR;
            end else if (dn_rvalid && dn_rready) begin
                dn_rvalid <= 1'b0;
            end
            if (dn_awvalid && dn_awready) begin
                got_aw      <= 1'b1;
                wa          <= dn_awaddr;
                aw_cnt      <= aw_cnt + 1;
                last_aw_cyc <= cyc;
            end
            if (dn_wvalid && dn_wready) begin
                got_w      <= 1'b1;
                wd         <= dn_wdata;
                ws         <= dn_wstrb;
                w_cnt      <= w_cnt + 1;
                last_w_cyc <= cyc;
            end
            if (got_aw && got_w) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mem[wa[5:2]][b*8 +: 8] <= wd[b*8 +: 8];
                dn_bvalid <= 1'b1;
                dn_bresp  <= wa[31] ? RESP_OKAY : RESP_SLVERR;
                got_aw    <= 1'b0;
                got_w     <= 1'b0;
            end else if (dn_bvalid && dn_bready) begin
                dn_bvalid <= 1'b0;
            end
        end
    end

    // Exclusivity: one master active, no read/write overlap, quiet IDLE.
    logic [NM-1:0] act;
    int bad_cnt = 0;
    assign act = up_arready | up_rvalid | up_awready
               | up_wready | up_bvalid;

    always @(negedge clk) begin
        if (!reset) begin
            if ($countones(act) > 1
                || (dn_arvalid && (dn_awvalid || dn_wvalid))
                || (!busy && (act != '0 || dn_arvalid
                    || dn_awvalid || dn_wvalid
                    || dn_rready || dn_bready)))
                bad_cnt++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int            m;
        logic          wr;
        logic [31:0]   data;
        logic [1:0]    resp;
        logic [NM-1:0] vec;
    } ev_t;

    ev_t evq[$];
    logic [NM-1:0] w_hold, w_arm;
    int w_dly[NM];

    task automatic issue_read(input int m, input logic [31:0] a);
        up_araddr[m*AW +: AW] = a;
        up_arvalid[m] = 1'b1;
    endtask

    task automatic issue_write(input int m, input logic [31:0] a,
                               input logic [31:0] d,
                               input logic [3:0] s, input int lead);
        up_awaddr[m*AW +: AW] = a;
        up_wdata[m*DW +: DW]  = d;
        up_wstrb[m*SW +: SW]  = s;
        up_awvalid[m] = 1'b1;
        if (lead == 0) up_wvalid[m] = 1'b1;
        else begin
            w_hold[m] = 1'b1;
            w_dly[m]  = lead - 2;
        end
    endtask

    // One cycle of master behaviour; completed R/B beats go to evq.
    task automatic step();
        logic [NM-1:0] arhs, rhs, awhs, whs, bhs;
        @(negedge clk);
        arhs = up_arvalid & up_arready;
        rhs  = up_rvalid & up_rready;
        awhs = up_awvalid & up_awready;
        whs  = up_wvalid & up_wready;
        bhs  = up_bvalid & up_bready;
        for (int m = 0; m < NM; m++) begin
            if (rhs[m])
                evq.push_back('{m, 1'b0, up_rdata[m*DW +: DW],
                                up_rresp[m*2 +: 2], up_rvalid});
            if (bhs[m])
                evq.push_back('{m, 1'b1, 32'h0,
                                up_bresp[m*2 +: 2], up_bvalid});
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < NM; m++) begin
            if (arhs[m]) up_arvalid[m] = 1'b0;
            if (whs[m])  up_wvalid[m]  = 1'b0;
            if (awhs[m]) begin
                up_awvalid[m] = 1'b0;
                if (w_hold[m]) begin
                    w_hold[m] = 1'b0;
                    w_arm[m]  = 1'b1;
                end
            end else if (w_arm[m]) begin
                if (w_dly[m] <= 0) begin
                    up_wvalid[m] = 1'b1;
                    w_arm[m]     = 1'b0;
                end else begin
                    w_dly[m]--;
                end
            end
        end
    endtask

    task automatic wait_events(input int n, input int budget,
                               input string tag);
        int k = 0;
        while (evq.size() < n && k < budget) begin
            step();
            k++;
        end
        check({tag, "_done"}, 64'(evq.size() >= n), 64'(1));
    endtask

    task automatic pop_ev(output ev_t e);
        if (evq.size() > 0) e = evq.pop_front();
        else begin
            e.m = -1;
            e.wr = 1'b0;
            e.data = '0;
            e.resp = '0;
            e.vec = '0;
        end
    endtask

    task automatic read_txn(input int m, input logic [31:0] a,
                            input logic [31:0] exp_d,
                            input logic [1:0] exp_r,
                            input string tag);
        ev_t e;
        issue_read(m, a);
        wait_events(1, 50, tag);
        pop_ev(e);
        check({tag, "_m"}, 64'(e.m), 64'(m));
        check({tag, "_data"}, 64'(e.data), 64'(exp_d));
        check({tag, "_resp"}, 64'(e.resp), 64'(exp_r));
        check({tag, "_vec"}, 64'(e.vec), 64'(1 << m));
    endtask

    task automatic write_txn(input int m, input logic [31:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s, input int lead,
                             input logic [1:0] exp_r,
                             input string tag);
        ev_t e;
        issue_write(m, a, d, s, lead);
        wait_events(1, 50, tag);
        pop_ev(e);
        check({tag, "_m"}, 64'(e.m), 64'(m));
        check({tag, "_resp"}, 64'(e.resp), 64'(exp_r));
        check({tag, "_bvec"}, 64'(e.vec), 64'(1 << m));
    endtask

    initial begin
        ev_t e;
        int got, k, base_aw, base_w, exp_m;
        int issued[NM];

        reset      = 1'b1;
        up_araddr  = {32'h8000_0004, 32'h8000_0008};
        up_arvalid = 2'b11;
        up_awaddr  = {32'h8000_0014, 32'h8000_0018};
        up_awvalid = 2'b11;
        up_wdata   = '1;
        up_wstrb   = '1;
        up_wvalid  = 2'b11;
        up_rready  = 2'b11;
        up_bready  = 2'b11;
        w_hold     = '0;
        w_arm      = '0;
        w_dly      = '{default: 0};

        // Reset holds every output at 0 even with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_dn_vr", 64'({dn_arvalid, dn_awvalid, dn_wvalid,
                                dn_rready, dn_bready}), 64'(0));
        check("rst_up_vr", 64'({up_arready, up_rvalid, up_awready,
                                up_wready, up_bvalid}), 64'(0));
        check("rst_dn_addr", {dn_araddr, dn_awaddr}, 64'(0));
        check("rst_up_rdata", up_rdata, 64'(0));
        up_arvalid = '0;
        up_awvalid = '0;
        up_wvalid  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        write_txn(0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0,
                  RESP_OKAY, "pre_wr");

        // Single read by master 1, cycle by cycle.
        issue_read(1, 32'h8000_0004);
        @(negedge clk);
        check("sr_idle_arvalid", 64'(dn_arvalid), 64'(0));
        check("sr_idle_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sr_arvalid", 64'(dn_arvalid), 64'(1));
        check("sr_araddr", 64'(dn_araddr), 64'h8000_0004);
        check("sr_arready", 64'(up_arready), 64'(2'b10));
        check("sr_busy", 64'(busy), 64'(1));
        @(posedge clk);
        #1;
        up_arvalid[1] = 1'b0;
        @(negedge clk);
        check("sr_rvalid", 64'(up_rvalid), 64'(2'b10));
        check("sr_rdata", up_rdata, {32'hDEAD_BEEF, 32'h0});
        check("sr_rresp", 64'(up_rresp), 64'(0));
        check("sr_m0_quiet", 64'({up_arready[0], up_rvalid[0]}),
              64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sr_end_busy", 64'(busy), 64'(0));

        // Split write: AW leads W by three cycles, halfword strobe.
        write_txn(0, 32'h8000_0010, 32'hAAAA_BBBB, 4'hF, 0,
                  RESP_OKAY, "sw_pre");
        base_aw = aw_cnt;
        base_w  = w_cnt;
        write_txn(1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 3,
                  RESP_OKAY, "sw");
        check("sw_aw_cnt", 64'(aw_cnt - base_aw), 64'(1));
        check("sw_w_cnt", 64'(w_cnt - base_w), 64'(1));
        check("sw_gap", 64'(last_w_cyc - last_aw_cyc), 64'(3));
        read_txn(0, 32'h8000_0010, 32'hAAAA_5678, RESP_OKAY, "sw_rd");

        // Contending reads; last grant was master 0 so the pointer is 1.
        issued = '{1, 1};
        issue_read(0, 32'h8000_0004);
        issue_read(1, 32'h0000_0008);
        got = 0;
        k = 0;
        while (got < 8 && k < 200) begin
            step();
            k++;
            while (evq.size() > 0) begin
                pop_ev(e);
`ifdef ARB_FIXED_PRIO_EN
                exp_m = (got < 4) ? 0 : 1;
`else
                exp_m = (got % 2 == 0) ? 1 : 0;
`endif
                check("rr_order", 64'(e.m), 64'(exp_m));
                check("rr_resp", 64'(e.resp),
                      64'((e.m == 0) ? RESP_OKAY : RESP_SLVERR));
                if (e.m >= 0 && e.m < NM && issued[e.m] < 4) begin
                    issue_read(e.m, (e.m == 0) ? 32'h8000_0004
                                               : 32'h0000_0008);
                    issued[e.m]++;
                end
                got++;
            end
        end
        check("rr_count", 64'(got), 64'(8));

        // Same master asks for read and write together: read first.
        issue_read(0, 32'h8000_0004);
        issue_write(0, 32'h8000_0008, 32'h0BAD_F00D, 4'hF, 0);
        wait_events(2, 60, "sm");
        pop_ev(e);
        check("sm_first_wr", 64'(e.wr), 64'(0));
        check("sm_first_data", 64'(e.data), 64'hDEAD_BEEF);
        pop_ev(e);
        check("sm_second_wr", 64'(e.wr), 64'(1));
        check("sm_second_m", 64'(e.m), 64'(0));

        // Back-pressure on R while master 1 waits for a grant.
        up_rready[0] = 1'b0;
        issue_read(0, 32'h8000_0008);
        k = 0;
        while (!up_rvalid[0] && k < 20) begin
            step();
            k++;
        end
        check("bp_rvalid_seen", 64'(up_rvalid[0]), 64'(1));
        issue_read(1, 32'h8000_0004);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_rvalid", 64'(up_rvalid), 64'(2'b01));
            check("bp_rdata", 64'(up_rdata[31:0]), 64'h0BAD_F00D);
            check("bp_no_grant", 64'(up_arready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
            @(posedge clk);
            #1;
        end
        up_rready[0] = 1'b1;
        wait_events(2, 60, "bp");
        pop_ev(e);
        check("bp_e0_m", 64'(e.m), 64'(0));
        check("bp_e0_data", 64'(e.data), 64'h0BAD_F00D);
        pop_ev(e);
        check("bp_e1_m", 64'(e.m), 64'(1));
        check("bp_e1_data", 64'(e.data), 64'hDEAD_BEEF);

        // Reset with master 1's AW accepted and W still pending.
        read_txn(0, 32'h8000_0004, 32'hDEAD_BEEF, RESP_OKAY, "pre_rst");
        base_aw = aw_cnt;
        issue_write(1, 32'h8000_0014, 32'hCAFE_0001, 4'hF, 10);
        k = 0;
        while (aw_cnt == base_aw && k < 20) begin
            step();
            k++;
        end
        check("mr_aw_seen", 64'(aw_cnt - base_aw), 64'(1));
        reset = 1'b1;
        #1;
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_dn_vr", 64'({dn_arvalid, dn_awvalid, dn_wvalid,
                               dn_rready, dn_bready}), 64'(0));
        check("mr_up_vr", 64'({up_arready, up_rvalid, up_awready,
                               up_wready, up_bvalid}), 64'(0));
        check("mr_dn_awaddr", 64'(dn_awaddr), 64'(0));
        up_awvalid = '0;
        up_wvalid  = '0;
        up_arvalid = '0;
        w_hold     = '0;
        w_arm      = '0;
        evq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_post_busy", 64'(busy), 64'(0));
        // A cleared pointer grants master 0 first.
        issue_write(0, 32'h0000_0020, 32'h1111_1111, 4'hF, 0);
        issue_write(1, 32'h8000_0014, 32'h5555_AAAA, 4'hF, 0);
        wait_events(2, 60, "mr");
        pop_ev(e);
        check("mr_e0_m", 64'(e.m), 64'(0));
        check("mr_e0_resp", 64'(e.resp), 64'(RESP_SLVERR));
        pop_ev(e);
        check("mr_e1_m", 64'(e.m), 64'(1));
        check("mr_e1_resp", 64'(e.resp), 64'(RESP_OKAY));
        read_txn(1, 32'h8000_0014, 32'h5555_AAAA, RESP_OKAY, "mr_rd");

        check("no_overlap", 64'(bad_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
